pwm_ramp_controller: RTL and testbench

- Configures a PWM generator by driving its pwm_max (period) and pwm_high_max (duty) inputs.
- Accepts period/duty/step commands from a host over a valid/ready handshake.
- Changes register values only at PWM period boundaries, so the generator never sees a torn period.
- Ramps duty by a fixed step per period toward the target (soft start/stop for motor drives).

---
 rtl/pwm_ramp_controller_pkg.sv | 16 +
 rtl/pwm_period_tracker.sv | 38 +++
 rtl/pwm_ramp_controller.sv | 190 +++++++++++++++++++
 tb/tb_pwm_ramp_controller.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/pwm_ramp_controller_pkg.sv
// ----------------------------------------------------------------------------
// pwm_ramp_controller_pkg
// Shared definitions for the PWM ramp controller and its period tracker:
//   - ramp_state_e        : controller state encoding (ST_HOLD, ST_RAMP)
//   - DEFAULT_RESET_PERIOD: pwm_max value driven out of reset by default
// ----------------------------------------------------------------------------
package pwm_ramp_controller_pkg;

  typedef enum logic {
    ST_HOLD = 1'b0,  // duty equals target
    ST_RAMP = 1'b1   // duty still moving toward target
  } ramp_state_e;

  localparam int unsigned DEFAULT_RESET_PERIOD = 1000;

endpackage

// File: rtl/pwm_period_tracker.sv
// ----------------------------------------------------------------------------
// pwm_period_tracker
// Mirrors the PWM generator's period counter so that consumers know where
// the period boundary is.
//   clock        : single clock
//   srst         : synchronous active-high reset
//   pwm_max      : period limit currently driven to the generator
//   boundary     : combinational, high on the cycle the counter equals pwm_max
//   period_start : registered, high on the cycle after the boundary (count 0)
// ----------------------------------------------------------------------------
module pwm_period_tracker #(
  parameter int unsigned PWM_WIDTH = 32
) (
  input  logic                 clock,
  input  logic                 srst,
  input  logic [PWM_WIDTH-1:0] pwm_max,
  output logic                 boundary,
  output logic                 period_start
);

  logic [PWM_WIDTH-1:0] count;

  // With pwm_max = 0 the counter sits at 0 and every cycle is a boundary.
  assign boundary = (count == pwm_max);

  // NOTE: sequential state is always assigned with <= so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (srst) begin
      count        <= '0;
      period_start <= 1'b0;
    end else begin
      period_start <= boundary;
      count        <= boundary ? '0 : count + PWM_WIDTH'(1);
    end
  end

endmodule

// File: rtl/pwm_ramp_controller.sv
// ----------------------------------------------------------------------------
// pwm_ramp_controller
// Drives pwm_max (period) and pwm_high_max (duty) of a PWM generator. Host
// commands arrive on a valid/ready handshake, are held pending and applied
// only at a period boundary. Duty ramps toward the target by a fixed step per
// boundary, saturating at the target in either direction.
//
// Ports:
//   clock, srst          : clock, synchronous active-high reset
//   cfg_valid/cfg_ready  : command handshake (cfg_ready = no command pending)
//   cfg_period           : target pwm_max
//   cfg_duty             : target pwm_high_max (clipped to cfg_period)
//   cfg_step             : duty change per boundary, 0 = jump immediately
//   cfg_prescale         : (PWM_RAMP_PRESCALE_EN only) step every N+1 periods
//   pwm_max, pwm_high_max: registered outputs to the generator
//   period_start         : one-cycle pulse at count 0 of each period
//   ramping              : high while duty differs from target
//   ramp_done            : one-cycle pulse when duty reaches target
//
// Build option: define PWM_RAMP_PRESCALE_EN to add the cfg_prescale input.
// ----------------------------------------------------------------------------
module pwm_ramp_controller
  import pwm_ramp_controller_pkg::*;
#(
  parameter int unsigned PWM_WIDTH    = 32,
  parameter int unsigned RESET_PERIOD = DEFAULT_RESET_PERIOD
) (
  input  logic                 clock,
  input  logic                 srst,
  input  logic                 cfg_valid,
  output logic                 cfg_ready,
  input  logic [PWM_WIDTH-1:0] cfg_period,
  input  logic [PWM_WIDTH-1:0] cfg_duty,
  input  logic [PWM_WIDTH-1:0] cfg_step,
`ifdef PWM_RAMP_PRESCALE_EN
  input  logic [15:0]          cfg_prescale,
`endif
  output logic [PWM_WIDTH-1:0] pwm_max,
  output logic [PWM_WIDTH-1:0] pwm_high_max,
  output logic                 period_start,
  output logic                 ramping,
  output logic                 ramp_done
);

  localparam logic [PWM_WIDTH-1:0] RESET_MAX = PWM_WIDTH'(RESET_PERIOD);

  ramp_state_e          state;
  logic                 pending;
  logic [PWM_WIDTH-1:0] pend_period;
  logic [PWM_WIDTH-1:0] pend_duty;
  logic [PWM_WIDTH-1:0] pend_step;
  logic [PWM_WIDTH-1:0] target;
  logic [PWM_WIDTH-1:0] step;

  logic                 boundary;
  logic                 accept;
  logic                 apply;
  logic                 step_en;

  logic [PWM_WIDTH-1:0] nxt_max;
  logic [PWM_WIDTH-1:0] nxt_target;
  logic [PWM_WIDTH-1:0] nxt_step;
  logic [PWM_WIDTH-1:0] base_duty;
  logic [PWM_WIDTH:0]   up_sum;
  logic [PWM_WIDTH:0]   down_reach;
  logic [PWM_WIDTH-1:0] nxt_duty;
  ramp_state_e          nxt_state;
  logic                 nxt_done;

  pwm_period_tracker #(
    .PWM_WIDTH (PWM_WIDTH)
  ) u_tracker (
    .clock        (clock),
    .srst         (srst),
    .pwm_max      (pwm_max),
    .boundary     (boundary),
    .period_start (period_start)
  );

  assign cfg_ready = !pending;
  assign accept    = cfg_valid && cfg_ready;
  assign apply     = boundary && pending;
  assign ramping   = (state == ST_RAMP);

`ifdef PWM_RAMP_PRESCALE_EN
  logic [15:0] pend_prescale;
  logic [15:0] prescale;
  logic [15:0] presc_cnt;

  // The apply boundary always moves duty; afterwards a step happens once the
  // counter has seen prescale+1 boundaries.
  assign step_en = apply || (presc_cnt == prescale);

  always_ff @(posedge clock) begin
    if (srst) begin
      prescale  <= '0;
      presc_cnt <= '0;
    end else if (boundary) begin
      if (apply) prescale <= pend_prescale;
      presc_cnt <= step_en ? '0 : presc_cnt + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (accept) pend_prescale <= cfg_prescale;
  end
`else
  assign step_en = 1'b1;
`endif

  // Values that would be in effect after this boundary; duty is first clamped
  // to the (possibly shrunken) period, then stepped toward the target.
  // NOTE: every output of this block gets a default first so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    nxt_max    = apply ? pend_period : pwm_max;
    nxt_target = target;
    nxt_step   = apply ? pend_step : step;
    if (apply) nxt_target = (pend_duty > pend_period) ? pend_period : pend_duty;

    base_duty  = (pwm_high_max > nxt_max) ? nxt_max : pwm_high_max;
    // One extra bit so base_duty + step cannot wrap past the target.
    up_sum     = {1'b0, base_duty} + {1'b0, nxt_step};
    down_reach = {1'b0, nxt_target} + {1'b0, nxt_step};

    nxt_duty   = base_duty;
    nxt_state  = ST_RAMP;
    nxt_done   = 1'b0;

    if (base_duty == nxt_target) begin
      nxt_state = ST_HOLD;
      nxt_done  = (state == ST_RAMP);
    end else if (step_en) begin
      if (base_duty < nxt_target) begin
        if (nxt_step == '0 || up_sum >= {1'b0, nxt_target}) begin
          nxt_duty  = nxt_target;
          nxt_state = ST_HOLD;
          nxt_done  = 1'b1;
        end else begin
          nxt_duty  = up_sum[PWM_WIDTH-1:0];
        end
      end else begin
        if (nxt_step == '0 || {1'b0, base_duty} <= down_reach) begin
          nxt_duty  = nxt_target;
          nxt_state = ST_HOLD;
          nxt_done  = 1'b1;
        end else begin
          nxt_duty  = base_duty - nxt_step;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (srst) begin
      pwm_max      <= RESET_MAX;
      pwm_high_max <= '0;
      target       <= '0;
      step         <= '0;
      state        <= ST_HOLD;
      pending      <= 1'b0;
      ramp_done    <= 1'b0;
    end else begin
      ramp_done <= 1'b0;
      // accept requires !pending and apply requires pending, so they never
      // collide in the same cycle.
      if (accept) pending <= 1'b1;
      if (boundary) begin
        pwm_max      <= nxt_max;
        pwm_high_max <= nxt_duty;
        target       <= nxt_target;
        step         <= nxt_step;
        state        <= nxt_state;
        ramp_done    <= nxt_done;
        if (apply) pending <= 1'b0;
      end
    end
  end

  // NOTE: the command data registers are left out of reset on purpose; they
  // are only read while pending is set, and pending itself is reset.
  always_ff @(posedge clock) begin
    if (accept) begin
      pend_period <= cfg_period;
      pend_duty   <= cfg_duty;
      pend_step   <= cfg_step;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// ----------------------------------------------------------------------------
// tb_pwm_ramp_controller
// Directed bench for pwm_ramp_controller with RESET_PERIOD = 9.
// ----------------------------------------------------------------------------
module tb_pwm_ramp_controller;

  localparam int unsigned W = 32;

  logic         clock = 1'b0;
  logic         srst  = 1'b1;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [W-1:0] cfg_period = '0;
  logic [W-1:0] cfg_duty   = '0;
  logic [W-1:0] cfg_step   = '0;
`ifdef PWM_RAMP_PRESCALE_EN
  logic [15:0]  cfg_prescale = '0;
`endif
  logic [W-1:0] pwm_max;
  logic [W-1:0] pwm_high_max;
  logic         period_start;
  logic         ramping;
  logic         ramp_done;

  int checks = 0;
  int errors = 0;
  int n;

  pwm_ramp_controller #(
    .PWM_WIDTH    (W),
    .RESET_PERIOD (9)
  ) dut (
    .clock        (clock),
    .srst         (srst),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_period   (cfg_period),
    .cfg_duty     (cfg_duty),
    .cfg_step     (cfg_step),
`ifdef PWM_RAMP_PRESCALE_EN
    .cfg_prescale (cfg_prescale),
`endif
    .pwm_max      (pwm_max),
    .pwm_high_max (pwm_high_max),
    .period_start (period_start),
    .ramping      (ramping),
    .ramp_done    (ramp_done)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit
  // after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Advance until period_start is seen, bounded; returns cycles taken.
  task automatic wait_ps(input string tag, output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!period_start && cycles < 150);
    check(tag, {31'd0, period_start}, 32'd1);
  endtask

  task automatic send(input logic [W-1:0] p, input logic [W-1:0] d, input logic [W-1:0] s);
    cfg_valid  = 1'b1;
    cfg_period = p;
    cfg_duty   = d;
    cfg_step   = s;
    tick();
    cfg_valid  = 1'b0;
    check("ready_low_after_accept", {31'd0, cfg_ready}, 32'd0);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    check("rst_pwm_max",      pwm_max,                9);
    check("rst_pwm_high_max", pwm_high_max,           0);
    check("rst_cfg_ready",    {31'd0, cfg_ready},     1);
    check("rst_period_start", {31'd0, period_start},  0);
    check("rst_ramping",      {31'd0, ramping},       0);
    check("rst_ramp_done",    {31'd0, ramp_done},     0);
    srst = 1'b0;

    // Idle periods: period_start every 10 cycles
    wait_ps("idle_ps0", n);
    wait_ps("idle_ps1", n);
    check("idle_period_len", n, 10);
    tick();
    check("ps_one_cycle", {31'd0, period_start}, 0);
    check("idle_hi", pwm_high_max, 0);

    // Upward ramp 0 -> 40 step 10, period 99
    send(99, 40, 10);
    wait_ps("up_ps1", n);
    check("up_max",  pwm_max,      99);
    check("up_hi1",  pwm_high_max, 10);
    check("up_ramping1", {31'd0, ramping}, 1);
    check("up_ready_back", {31'd0, cfg_ready}, 1);
    wait_ps("up_ps2", n);
    check("up_period_len", n, 100);
    check("up_hi2",  pwm_high_max, 20);
    check("up_done2", {31'd0, ramp_done}, 0);
    wait_ps("up_ps3", n);
    check("up_hi3",  pwm_high_max, 30);
    wait_ps("up_ps4", n);
    check("up_hi4",  pwm_high_max, 40);
    check("up_done4", {31'd0, ramp_done}, 1);
    check("up_ramping4", {31'd0, ramping}, 0);
    tick();
    check("up_done_pulse", {31'd0, ramp_done}, 0);

    // Downward ramp 40 -> 5 step 10
    send(99, 5, 10);
    wait_ps("dn_ps1", n);
    check("dn_hi1", pwm_high_max, 30);
    wait_ps("dn_ps2", n);
    check("dn_hi2", pwm_high_max, 20);
    wait_ps("dn_ps3", n);
    check("dn_hi3", pwm_high_max, 10);
    check("dn_done3", {31'd0, ramp_done}, 0);
    wait_ps("dn_ps4", n);
    check("dn_hi4", pwm_high_max, 5);
    check("dn_done4", {31'd0, ramp_done}, 1);
    check("dn_ramping4", {31'd0, ramping}, 0);

    // Step 0 jumps straight to 40
    send(99, 40, 0);
    wait_ps("jump_ps", n);
    check("jump_hi", pwm_high_max, 40);
    check("jump_done", {31'd0, ramp_done}, 1);

    // Period shrinks below duty: clamp
    send(20, 50, 5);
    wait_ps("clamp_ps", n);
    check("clamp_max", pwm_max, 20);
    check("clamp_hi",  pwm_high_max, 20);
    check("clamp_ramping", {31'd0, ramping}, 0);

    // Back-to-back: A ramps 20 -> 0 step 5, B blocked then retargets to 18 step 2
    send(20, 0, 5);
    cfg_valid  = 1'b1;
    cfg_period = 20;
    cfg_duty   = 18;
    cfg_step   = 2;
    check("b2b_blocked", {31'd0, cfg_ready}, 0);
    wait_ps("b2b_ps1", n);
    check("b2b_hi1", pwm_high_max, 15);
    check("b2b_ready_at_ps", {31'd0, cfg_ready}, 1);
    tick();
    cfg_valid = 1'b0;
    check("b2b_b_accepted", {31'd0, cfg_ready}, 0);
    wait_ps("b2b_ps2", n);
    check("b2b_retarget_hi", pwm_high_max, 17);
    check("b2b_ramping", {31'd0, ramping}, 1);
    wait_ps("b2b_ps3", n);
    check("b2b_hi3", pwm_high_max, 18);
    check("b2b_done", {31'd0, ramp_done}, 1);

    // srst mid-ramp with a pending command
    send(20, 0, 1);
    wait_ps("srst_ps1", n);
    check("srst_pre_hi", pwm_high_max, 17);
    check("srst_pre_ramping", {31'd0, ramping}, 1);
    send(50, 30, 3);
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check("srst_max",     pwm_max, 9);
    check("srst_hi",      pwm_high_max, 0);
    check("srst_ready",   {31'd0, cfg_ready}, 1);
    check("srst_ramping", {31'd0, ramping}, 0);
    check("srst_ps",      {31'd0, period_start}, 0);
    wait_ps("srst_post_ps1", n);
    check("srst_post_len1", n, 10);
    wait_ps("srst_post_ps2", n);
    check("srst_post_max", pwm_max, 9);
    check("srst_post_hi",  pwm_high_max, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
